// File: rtl/shift_add_mult_ctrl.sv
// -----------------------------------------------------------------------------
// shift_add_mult_ctrl
//
// Sequential unsigned shift-and-add multiplier. A start in IDLE captures A and
// B. Each RUN cycle then adds one partial product into a 2W-bit accumulator.
// The block spends one DONE cycle presenting the product before it returns to
// IDLE.
//
// Handshake: a start is accepted only on a rising edge where the FSM is in
// IDLE, which is the same as busy=0. While busy=1 (RUN or DONE), start is
// ignored and no request is queued. done is a one-cycle pulse during DONE. In
// that cycle P holds the product, and P keeps it until the next DONE or reset.
//
// Optional feature (macro EARLY_TERM_EN): RUN ends after the first step whose
// post-shift multiplier is zero. Without the macro, RUN always lasts W cycles.
//
// Ports:
//   clk        in   1    clock, all state updates on rising edge
//   rst        in   1    synchronous active-high reset
//   start      in   1    multiply request, sampled only in IDLE
//   A          in   W    multiplicand, captured on accepted start
//   B          in   W    multiplier, captured on accepted start
//   P          out  2W   product register
//   busy       out  1    registered, high in RUN and DONE
//   done       out  1    one-cycle pulse while P is newly valid
//   dbg_state  out  2    current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module shift_add_mult_ctrl #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  output logic [2*W-1:0]   P,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int IW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     mcand_q, mcand_d;
  logic [W-1:0]     mreg_q,  mreg_d;
  logic [2*W-1:0]   acc_q,   acc_d;
  logic [IW-1:0]    i_q,     i_d;
  logic [2*W-1:0]   p_q,     p_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic [2*W-1:0]   pp;
  logic [2*W-1:0]   acc_step;
  logic [W-1:0]     mreg_shift;
  logic             last_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mreg_q  <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mreg_q  <= mreg_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    // Partial product for the current multiplier LSB, aligned to bit i.
    pp         = {{W{1'b0}}, mcand_q & {W{mreg_q[0]}}} << i_q;
    acc_step   = acc_q + pp;
    mreg_shift = mreg_q >> 1;
`ifdef EARLY_TERM_EN
    // No set bits remain, so every later partial product would be zero.
    last_step  = (mreg_shift == '0);
`else
    last_step  = (i_q == IW'(W - 1));
`endif

    state_d = state_q;
    mcand_d = mcand_q;
    mreg_d  = mreg_q;
    acc_d   = acc_q;
    i_d     = i_q;
    p_d     = p_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mcand_d = A;
          mreg_d  = B;
          acc_d   = '0;
          i_d     = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        acc_d  = acc_step;
        mreg_d = mreg_shift;
        i_d    = i_q + IW'(1);
        if (last_step) begin
          state_d = DONE;
          p_d     = acc_step;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign P         = p_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
